// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    // Default command/response word width
    localparam int SPI_DATA_W = 32;

    // Default response watchdog limit in cycles
    localparam int SPI_TIMEOUT_CYCLES = 1024;

endpackage : spi_pkg

// File: rtl/rr_picker.sv
// Round-robin selector: returns the first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on idx/any.
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan offsets from farthest to nearest so the entry closest to ptr wins
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule : rr_picker

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI controller; grant stays locked across a multi-word transaction.
// Latency: 1 cycle to arbitrate, command passes through combinationally, response registered (+1 cycle).
// Backpressure: req_ready of the owner mirrors cmd_ready; one word outstanding; optional watchdog via SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_W         = SPI_DATA_W,
    parameter int TIMEOUT_CYCLES = SPI_TIMEOUT_CYCLES
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [DATA_W-1:0]          cmd_data,
    output logic                       cmd_last,
    input  logic                       eng_rsp_valid,
    input  logic [DATA_W-1:0]          eng_rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic               last_q;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               take_grant;
    logic               accept;
    logic               rsp_fire;
    logic               xfer_done;
    logic               timeout_hit;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign busy = (state != IDLE);

    // One-hot of the current owner, used to steer the response strobe
    always_comb begin
        grant_onehot           = '0;
        grant_onehot[grant_id] = 1'b1;
    end

    // Next round starts just past the owner that finished, so it gets lowest priority
    always_comb begin
        if (grant_id == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_id + IDX_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and command-side outputs
    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_last   = 1'b0;
        req_ready  = '0;
        take_grant = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    take_grant = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Grant stays with the owner even while it has nothing to offer
                cmd_valid           = req_valid[grant_id];
                cmd_data            = req_data[int'(grant_id) * DATA_W +: DATA_W];
                cmd_last            = req_last[grant_id];
                req_ready[grant_id] = cmd_ready;
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (eng_rsp_valid) begin
                    rsp_fire = 1'b1;
                    if (last_q) begin
                        xfer_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = ISSUE;
                    end
                end else if (timeout_hit) begin
                    // Abort drops the remainder of the transaction
                    xfer_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant, round-robin pointer, last-word flag and registered response
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            last_q    <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (take_grant) begin
                grant_id <= pick_idx;
            end
            if (accept) begin
                last_q <= req_last[grant_id];
            end
            if (rsp_fire) begin
                rsp_valid <= grant_onehot;
                rsp_data  <= eng_rsp_data;
            end else if (timeout_hit) begin
                rsp_valid <= grant_onehot;
                rsp_data  <= '0;
            end
            if (xfer_done) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             rsp_err_q;

    // A real response in the final watchdog cycle takes precedence over the abort
    assign timeout_hit = (state == WAIT_RSP) && !eng_rsp_valid &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = rsp_err_q;

    // Watchdog counts cycles spent in WAIT_RSP, zero on entry
    always_ff @(posedge sys_clk) begin
        if (rst || (state != WAIT_RSP)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Error flag travels with the registered response strobe
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;

    // Without the watchdog the limit only matters for a degenerate setting
    if (TIMEOUT_CYCLES < 1) begin : g_no_timeout_limit
    end
`endif

endmodule : spi_txn_arbiter

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: single word, round robin, locked transaction, backpressure, reset, watchdog.
// Latency: checks sampled 1-2 time units after the rising edge.
// Backpressure: exercised by holding cmd_ready low.
module tb_spi_txn_arbiter;

    logic        sys_clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_last;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        cmd_last;
    logic        eng_rsp_valid;
    logic [31:0] eng_rsp_data;
    logic [1:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    spi_txn_arbiter #(
        .NUM_REQ        (3),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_last      (cmd_last),
        .eng_rsp_valid (eng_rsp_valid),
        .eng_rsp_data  (eng_rsp_data),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [31:0] d);
        req_valid[i]        = v;
        req_last[i]         = l;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        cmd_ready     = 1'b0;
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = '0;

        // Reset values
        tick();
        tick();
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_grant",     32'(grant_id),  32'h0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst_cmd_data",  cmd_data,       32'h0);
        chk("rst_cmd_last",  32'(cmd_last),  32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  rsp_data,       32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        rst = 1'b0;

        // Single requester, single word
        set_req(1, 1'b1, 1'b1, 32'hA5A5_0001);
        cmd_ready = 1'b1;
        tick();
        chk("t1_cmd_valid", 32'(cmd_valid), 32'h1);
        chk("t1_cmd_data",  cmd_data,       32'hA5A5_0001);
        chk("t1_cmd_last",  32'(cmd_last),  32'h1);
        chk("t1_grant",     32'(grant_id),  32'h1);
        chk("t1_req_ready", 32'(req_ready), 32'h2);
        chk("t1_busy",      32'(busy),      32'h1);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h1234_5678;
        #1;
        chk("t1_wait_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("t1_wait_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t1_rsp_data",  rsp_data,       32'h1234_5678);
        chk("t1_rsp_err",   32'(rsp_err),   32'h0);
        chk("t1_busy_low",  32'(busy),      32'h0);
        tick();
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Round robin from a fresh reset, all requesters asserting, engine answering at once
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, 1'b1, 32'hC0DE_0000 + 32'(i));
        end
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h5555_AAAA;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_grant",     32'(grant_id),  32'(k % 3));
            chk("rr_cmd_data",  cmd_data,       32'hC0DE_0000 + 32'(k % 3));
            chk("rr_no_stray",  32'(rsp_valid), 32'h0);
            tick();
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1 << (k % 3));
        end
        req_valid     = '0;
        eng_rsp_valid = 1'b0;
        tick();

        // Locked 3-word transaction from requester 0 while requester 2 waits
        set_req(0, 1'b1, 1'b0, 32'h0A00_0000);
        set_req(2, 1'b1, 1'b1, 32'h2222_0002);
        tick();
        chk("lk_grant0",    32'(grant_id), 32'h0);
        chk("lk_cmd_data0", cmd_data,      32'h0A00_0000);
        chk("lk_cmd_last0", 32'(cmd_last), 32'h0);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h0000_0101;
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("lk_rsp0",  32'(rsp_valid), 32'h1);
        chk("lk_busy0", 32'(busy),      32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("lk_gap_grant",     32'(grant_id),  32'h0);
            chk("lk_gap_cmd_valid", 32'(cmd_valid), 32'h0);
            chk("lk_gap_req_ready", 32'(req_ready), 32'h1);
            tick();
        end
        set_req(0, 1'b1, 1'b0, 32'h0A00_0001);
        #1;
        chk("lk_cmd_data1", cmd_data,      32'h0A00_0001);
        chk("lk_grant1",    32'(grant_id), 32'h0);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        tick();
        eng_rsp_valid = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h0A00_0002);
        #1;
        chk("lk_rsp1",      32'(rsp_valid), 32'h1);
        chk("lk_cmd_last2", 32'(cmd_last),  32'h1);
        chk("lk_grant2",    32'(grant_id),  32'h0);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("lk_rsp2",      32'(rsp_valid), 32'h1);
        chk("lk_busy_done", 32'(busy),      32'h0);
        tick();
        chk("lk_next_grant", 32'(grant_id), 32'h2);
        chk("lk_next_data",  cmd_data,      32'h2222_0002);
        tick();
        set_req(2, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h0000_0202;
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("lk_rsp_req2", 32'(rsp_valid), 32'h4);

        // Backpressure: cmd_ready low for 10 cycles
        cmd_ready = 1'b0;
        set_req(1, 1'b1, 1'b1, 32'hBEEF_0011);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmd_valid", 32'(cmd_valid), 32'h1);
            chk("bp_cmd_data",  cmd_data,       32'hBEEF_0011);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        chk("bp_ready_on", 32'(req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'hCAFE_0001;
        #1;
        chk("bp_accepted", 32'(cmd_valid), 32'h0);
        chk("bp_busy",     32'(busy),      32'h1);
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("bp_rsp_data",  rsp_data,       32'hCAFE_0001);

        // Reset in WAIT_RSP with a late engine response afterwards
        set_req(1, 1'b1, 1'b1, 32'h0BAD_0001);
        tick();
        tick();
        chk("mr_busy_wait", 32'(busy),     32'h1);
        chk("mr_grant1",    32'(grant_id), 32'h1);
        rst = 1'b1;
        tick();
        chk("mr_busy",      32'(busy),      32'h0);
        chk("mr_grant",     32'(grant_id),  32'h0);
        chk("mr_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("mr_cmd_data",  cmd_data,       32'h0);
        chk("mr_cmd_last",  32'(cmd_last),  32'h0);
        chk("mr_req_ready", 32'(req_ready), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr_rsp_data",  rsp_data,       32'h0);
        rst = 1'b0;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'hDEAD_0000;
        set_req(0, 1'b1, 1'b1, 32'h0000_0F00);
        set_req(2, 1'b1, 1'b1, 32'h0000_0F02);
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("mr_first_grant", 32'(grant_id),  32'h0);
        chk("mr_late_drop",   32'(rsp_valid), 32'h0);
        chk("mr_cmd_data0",   cmd_data,       32'h0000_0F00);
        tick();
        req_valid     = '0;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h7777_0000;
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("mr_rsp0", 32'(rsp_valid), 32'h1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog abort with no engine response
        set_req(1, 1'b1, 1'b1, 32'h0000_7001);
        tick();
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            chk("to_quiet", 32'(rsp_valid), 32'h0);
            tick();
        end
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("to_rsp_err",   32'(rsp_err),   32'h1);
        chk("to_rsp_data",  rsp_data,       32'h0);
        chk("to_idle",      32'(busy),      32'h0);

        // Engine response in the final watchdog cycle wins
        set_req(2, 1'b1, 1'b1, 32'h0000_7002);
        tick();
        tick();
        set_req(2, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            chk("to2_quiet", 32'(rsp_valid), 32'h0);
            tick();
        end
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = 32'h600D_0016;
        tick();
        eng_rsp_valid = 1'b0;
        #1;
        chk("to2_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("to2_rsp_err",   32'(rsp_err),   32'h0);
        chk("to2_rsp_data",  rsp_data,       32'h600D_0016);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_txn_arbiter

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter that shares the single SPI controller between several on-chip requesters, e.g. the APB register path, the RF front-end configuration sequencer and a boot-time loader. Each requester issues word-sized SPI commands. A multi-word transaction keeps the grant locked until its last word's response returns, so chip-select framing is never interleaved. Sits in `sys_clk` domain between requesters and `spi_ctrl_top`'s command/response port.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `DATA_W`, 32: command/response word width.
- `TIMEOUT_CYCLES`, 1024: response watchdog limit; used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `sys_clk` in 1: single clock; everything synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_last` in NUM_REQ: word is the last of its transaction; CS is released after it.
- `req_data` in NUM_REQ*DATA_W: packed command words; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` out NUM_REQ: per-requester command accept.
- `rsp_valid` out NUM_REQ: one-cycle response strobe to the owning requester.
- `rsp_data` out DATA_W: shared response word, valid with any `rsp_valid` bit.
- `rsp_err` out 1: response was a watchdog abort; 0 when timeout is compiled out.
- `cmd_valid` out 1, `cmd_ready` in 1, `cmd_data` out DATA_W, `cmd_last` out 1: to SPI controller.
- `eng_rsp_valid` in 1, `eng_rsp_data` in DATA_W: response from SPI controller.
- `grant_id` out $clog2(NUM_REQ): current owner.
- `busy` out 1: transaction in progress (state != IDLE).

## Operation
- FSM states are IDLE, ISSUE and WAIT_RSP. At most one word is outstanding at the engine.
- **IDLE.** If any `req_valid` is set, select the first requester at or after `rr_ptr`, wrapping modulo NUM_REQ. Register it into `grant_id`, then go to ISSUE. With no requests, stay in IDLE.
- **ISSUE.**
  - Drive `cmd_valid`, `cmd_data` and `cmd_last` from the granted requester; `req_ready[grant_id]` = `cmd_ready`. All other `req_ready` bits are 0.
  - On `cmd_valid && cmd_ready`, latch `last_q` = `req_last[grant]` and go to WAIT_RSP.
  - If the granted requester deasserts `req_valid` mid-transaction, the grant stays locked and the FSM waits in ISSUE.
- **WAIT_RSP.**
  - On `eng_rsp_valid`: pulse `rsp_valid[grant_id]` for one cycle, with `rsp_data` = `eng_rsp_data` and `rsp_err` = 0.
  - If `last_q` is set, go to IDLE and set `rr_ptr` = grant_id+1 (wrapping NUM_REQ-1 to 0). Otherwise return to ISSUE.
- `eng_rsp_valid` outside WAIT_RSP is dropped. No `rsp_valid` is produced for it.
- Reset, including mid-transaction:
  - FSM goes to IDLE; `rr_ptr` = 0; `grant_id` = 0; `last_q` = 0.
  - Outputs: `cmd_valid` 0, `cmd_last` 0, `cmd_data` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `busy` 0.
  - Any in-flight engine response arriving after reset is dropped.

## Timing
- Arbitration takes 1 cycle. A request asserted in IDLE at cycle N is offered on `cmd_valid` at cycle N+1.
- The earliest accept is at N+1. `rsp_valid` is registered and appears 1 cycle after `eng_rsp_valid`.
- Back-to-back words of one transaction: ISSUE is re-entered the cycle after the response strobe.
- A new arbitration starts the cycle after returning to IDLE, so there is at least 1 idle cycle between transactions. IDLE never re-grants in the same cycle it is entered.
- Simultaneous requests are resolved purely by `rr_ptr`. A requester that just finished has the lowest priority next round.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT_RSP and increments each cycle in WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES-1 with no `eng_rsp_valid`, pulse `rsp_valid[grant_id]` with `rsp_err` = 1 and `rsp_data` = 0.
  - Then force IDLE regardless of `last_q` and advance `rr_ptr`.
  - If `eng_rsp_valid` arrives in the same cycle as the timeout, the response wins.
- **Not defined:** no counter, `rsp_err` is tied to 0, and WAIT_RSP waits indefinitely.

## Structure
- Shared package `spi_pkg`: the state enum (IDLE/ISSUE/WAIT_RSP), the `DATA_W` default, and the `TIMEOUT_CYCLES` default.
- One sub-module, `rr_picker`: combinational round-robin selector taking the request vector and `rr_ptr`, returning index and any-valid. It is reused by other arbiters.

## Test plan
- **Single requester.** Requester 1 sends one word 0xA5A5_0001 with last=1 and the engine answers 0x1234_5678 → `cmd_data` = 0xA5A5_0001 with `cmd_last` = 1; `rsp_valid` = 3'b010 for 1 cycle; `rsp_data` = 0x1234_5678; `busy` low 1 cycle later.
- **Round-robin fairness.** All 3 requesters hold single-word requests continuously → grant order 0,1,2,0,1,2; no requester is served twice before the others.
- **Locked transaction.** Requester 0 sends a 3-word transaction while requester 2 is requesting, and requester 0 drops `req_valid` for 5 cycles between words → `grant_id` stays 0 throughout and requester 2 is granted only after the third response.
- **Backpressure.** `cmd_ready` is held 0 for 10 cycles → `cmd_valid` and `cmd_data` stay stable and `req_ready` stays 0; the accept happens on the first ready cycle.
- **Reset mid-transaction.** Assert `rst` in WAIT_RSP, then deliver a late `eng_rsp_valid` → all outputs are at reset values, no `rsp_valid`, and requester 0 is granted first afterwards.
- **Timeout (`SPI_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16).** No engine response → `rsp_valid` with `rsp_err` = 1 exactly 16 cycles into WAIT_RSP, then IDLE. A response on cycle 16 instead → `rsp_err` = 0.
